// File: rtl/core_ctrl_fsm_if.sv
// core_ctrl_fsm_if: handshake and control bundle between the sequencer and the rest of the core
interface core_ctrl_fsm_if #(parameter int INSTRET_W = 32);
  logic                 imem_ack;
  logic [3:0]           instr_kind;
  logic                 branch_taken;
  logic                 dmem_ack;
  logic                 imem_req;
  logic                 ir_we;
  logic                 dmem_req;
  logic                 dmem_we;
  logic                 pc_we;
  logic [1:0]           pc_sel;
  logic                 rf_we;
  logic [1:0]           wb_sel;
  logic                 retire;
  logic [INSTRET_W-1:0] instret;
  logic                 trap;
  logic [1:0]           trap_cause;
  logic [2:0]           state_o;
  modport master (
    input  imem_ack, instr_kind, branch_taken, dmem_ack,
    output imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_sel, rf_we, wb_sel,
           retire, instret, trap, trap_cause, state_o
  );
  modport slave (
    output imem_ack, instr_kind, branch_taken, dmem_ack,
    input  imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_sel, rf_we, wb_sel,
           retire, instret, trap, trap_cause, state_o
  );
endinterface

// File: rtl/core_ctrl_fsm.sv
// core_ctrl_fsm: multi-cycle RV32I sequencer FETCH -> DECODE -> EXEC -> [MEM] -> WB with memory
// timeouts, illegal-instruction trap and retired-instruction counter.
module core_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TIMEOUT_W   = 8,
  parameter int INSTRET_W   = 32
) (
  input logic             clk,
  input logic             rst_n,
  core_ctrl_fsm_if.master bus
);
  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, TRAP = 3'd5} state_t;
  localparam logic [3:0] K_LUI = 4'd1, K_JAL = 4'd3, K_JALR = 4'd4, K_BRANCH = 4'd5,
                         K_LOAD = 4'd6, K_STORE = 4'd7, K_FENCE = 4'd10;
  state_t                state, state_n;
  logic                  run, trap_seen, waiting, timeout;
  logic [TIMEOUT_W-1:0]  wcnt;
  logic [3:0]            kind;
  logic [1:0]            cause;
  logic [INSTRET_W-1:0]  ret_cnt;
  // run holds off the first fetch request until the first edge after reset release
  assign waiting = state == MEM || (state == FETCH && run);
  assign timeout = wcnt == TIMEOUT_W'(MEM_TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      run       <= 1'b0;
      trap_seen <= 1'b0;
      wcnt      <= '0;
      kind      <= '0;
      cause     <= '0;
      ret_cnt   <= '0;
    end else begin
      state     <= state_n;
      run       <= 1'b1;
      trap_seen <= state == TRAP;
      wcnt      <= (waiting && state_n == state) ? wcnt + 1'b1 : '0;
      kind      <= state == DECODE ? bus.instr_kind : kind;
      cause     <= (state_n == TRAP && state != TRAP) ? (state == MEM ? 2'd2 : state == FETCH ? 2'd1 : 2'd0) : cause;
      ret_cnt   <= ret_cnt + INSTRET_W'(state == WB);
    end
  end
  always_comb begin
    state_n      = state;
    bus.imem_req = 1'b0;
    bus.ir_we    = 1'b0;
    bus.dmem_req = 1'b0;
    bus.dmem_we  = 1'b0;
    bus.pc_we    = 1'b0;
    bus.pc_sel   = 2'b00;
    bus.rf_we    = 1'b0;
    bus.wb_sel   = 2'b00;
    bus.retire   = 1'b0;
    case (state)
      FETCH: begin
        bus.imem_req = run;
        bus.ir_we    = run && bus.imem_ack;
        state_n      = !run ? FETCH : bus.imem_ack ? DECODE : timeout ? TRAP : FETCH;
      end
      DECODE: state_n = (bus.instr_kind >= K_LUI && bus.instr_kind <= K_FENCE) ? EXEC : TRAP;
      EXEC:   state_n = (kind == K_LOAD || kind == K_STORE) ? MEM : WB;
      MEM: begin
        bus.dmem_req = 1'b1;
        bus.dmem_we  = kind == K_STORE;
        state_n      = bus.dmem_ack ? WB : timeout ? TRAP : MEM;
      end
      WB: begin
        bus.pc_we  = 1'b1;
        bus.retire = 1'b1;
        bus.pc_sel = (kind == K_JAL || (kind == K_BRANCH && bus.branch_taken)) ? 2'b01 :
                     kind == K_JALR ? 2'b10 : 2'b00;
        bus.rf_we  = !(kind == K_BRANCH || kind == K_STORE || kind == K_FENCE);
        bus.wb_sel = kind == K_LUI ? 2'b11 : kind == K_LOAD ? 2'b01 :
                     (kind == K_JAL || kind == K_JALR) ? 2'b10 : 2'b00;
        state_n    = FETCH;
      end
      TRAP: begin
        bus.pc_we  = !trap_seen;
        bus.pc_sel = trap_seen ? 2'b00 : 2'b11;
      end
      default: state_n = TRAP;
    endcase
  end
  assign bus.trap       = state == TRAP;
  assign bus.trap_cause = cause;
  assign bus.state_o    = state;
  assign bus.instret    = ret_cnt;
endmodule

// File: tb/tb_core_ctrl_fsm.sv
// tb_core_ctrl_fsm: randomized scenario bench comparing the sequencer cycle by cycle against
// expectations derived from the instruction-kind rules and wait/timeout arithmetic.
module tb_core_ctrl_fsm;
  localparam int TO = 4;
  localparam logic [3:0] LUI = 4'd1, AUIPC = 4'd2, JAL = 4'd3, JALR = 4'd4, BRANCH = 4'd5,
                         LOAD = 4'd6, STORE = 4'd7, OPIMM = 4'd8, OP = 4'd9, FENCE = 4'd10;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          checks = 0;
  int          passed = 0;
  logic [31:0] exp_ret = '0;

  core_ctrl_fsm_if #(.INSTRET_W(32)) bus();
  core_ctrl_fsm #(.MEM_TIMEOUT(TO), .TIMEOUT_W(8), .INSTRET_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  wire [16:0] obs = {bus.state_o, bus.imem_req, bus.ir_we, bus.dmem_req, bus.dmem_we, bus.pc_we,
                     bus.pc_sel, bus.rf_we, bus.wb_sel, bus.retire, bus.trap, bus.trap_cause};

  function automatic logic [16:0] ev(logic [2:0] st, logic ireq, logic irwe, logic dreq, logic dwe,
                                     logic pcwe, logic [1:0] pcs, logic rfwe, logic [1:0] wbs,
                                     logic ret, logic trp, logic [1:0] cause);
    return {st, ireq, irwe, dreq, dwe, pcwe, pcs, rfwe, wbs, ret, trp, cause};
  endfunction

  function automatic logic [1:0] m_pcsel(logic [3:0] k, logic tk);
    if (k == JAL) return 2'b01;
    if (k == JALR) return 2'b10;
    if (k == BRANCH) return tk ? 2'b01 : 2'b00;
    return 2'b00;
  endfunction

  function automatic logic m_rfwe(logic [3:0] k);
    return !(k == BRANCH || k == STORE || k == FENCE);
  endfunction

  function automatic logic [1:0] m_wbsel(logic [3:0] k);
    if (k == LUI) return 2'b11;
    if (k == LOAD) return 2'b01;
    if (k == JAL || k == JALR) return 2'b10;
    return 2'b00;
  endfunction

  task automatic junk();
    bus.imem_ack     = 1'($urandom);
    bus.dmem_ack     = 1'($urandom);
    bus.branch_taken = 1'($urandom);
  endtask

  // iw/dw: wait cycles before the ack; values >= TO never ack and must time out
  task automatic run_instr(string nm, logic [3:0] k, int iw, int dw, logic tk);
    int          tc = -1;
    logic [16:0] e;
    logic        legal = k >= LUI && k <= FENCE;
    for (int c = 0; c < ((iw < TO) ? iw + 1 : TO); c++) begin
      @(negedge clk);
      junk();
      bus.imem_ack   = c == iw;
      bus.instr_kind = 4'($urandom);
      #1;
      e = ev(3'd0, 1, c == iw, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 2'd0);
      checks++;
      if (obs !== e) $display("FAIL %s fetch[%0d]: outputs %h, required %h", nm, c, obs, e);
      else passed++;
      if (c == 0) begin
        checks++;
        if (bus.instret !== exp_ret) $display("FAIL %s instret: got %0d, required %0d", nm, bus.instret, exp_ret);
        else passed++;
      end
    end
    if (iw >= TO) tc = 1;
    else begin
      @(negedge clk);
      junk();
      bus.imem_ack   = 1'b0;
      bus.instr_kind = k;
      #1;
      e = ev(3'd1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 2'd0);
      checks++;
      if (obs !== e) $display("FAIL %s decode: outputs %h, required %h", nm, obs, e);
      else passed++;
      if (!legal) tc = 0;
      else begin
        @(negedge clk);
        junk();
        #1;
        e = ev(3'd2, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 2'd0);
        checks++;
        if (obs !== e) $display("FAIL %s exec: outputs %h, required %h", nm, obs, e);
        else passed++;
        if (k == LOAD || k == STORE) begin
          for (int c = 0; c < ((dw < TO) ? dw + 1 : TO); c++) begin
            @(negedge clk);
            junk();
            bus.dmem_ack = c == dw;
            #1;
            e = ev(3'd3, 0, 0, 1, k == STORE, 0, 2'b00, 0, 2'b00, 0, 0, 2'd0);
            checks++;
            if (obs !== e) $display("FAIL %s mem[%0d]: outputs %h, required %h", nm, c, obs, e);
            else passed++;
          end
          if (dw >= TO) tc = 2;
        end
        if (tc < 0) begin
          @(negedge clk);
          junk();
          bus.branch_taken = tk;
          #1;
          e = ev(3'd4, 0, 0, 0, 0, 1, m_pcsel(k, tk), m_rfwe(k), m_wbsel(k), 1, 0, 2'd0);
          checks++;
          if (obs !== e) $display("FAIL %s wb: outputs %h, required %h", nm, obs, e);
          else passed++;
          exp_ret++;
        end
      end
    end
    if (tc >= 0) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        junk();
        #1;
        e = ev(3'd5, 0, 0, 0, 0, c == 0, (c == 0) ? 2'b11 : 2'b00, 0, 2'b00, 0, 1, 2'(tc));
        checks++;
        if (obs !== e) $display("FAIL %s trap[%0d]: outputs %h, required %h", nm, c, obs, e);
        else passed++;
      end
      checks++;
      if (bus.instret !== exp_ret) $display("FAIL %s trap instret: got %0d, required %0d", nm, bus.instret, exp_ret);
      else passed++;
    end
  endtask

  task automatic do_reset(string nm);
    @(negedge clk);
    junk();
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 17'd0 || bus.instret !== 32'd0) $display("FAIL %s in reset: outputs %h instret %0d, required 0", nm, obs, bus.instret);
    else passed++;
    @(negedge clk);
    junk();
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs !== 17'd0) $display("FAIL %s release: outputs %h, required 0", nm, obs);
    else passed++;
    exp_ret = '0;
  endtask

  task automatic test_reset();
    do_reset("reset");
  endtask

  task automatic test_lui();
    run_instr("lui", LUI, 0, 0, 1'b0);
  endtask

  task automatic test_store();
    run_instr("store", STORE, 1, 3, 1'b0);
  endtask

  task automatic test_branch();
    run_instr("br_taken", BRANCH, 0, 0, 1'b1);
    run_instr("br_not", BRANCH, 2, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [3:0] kinds[10] = '{LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, FENCE};
    for (int i = 0; i < 40; i++)
      run_instr("random", kinds[$urandom_range(0, 9)], $urandom_range(0, TO - 1),
                $urandom_range(0, TO - 1), 1'($urandom));
    run_instr("late_ack", LOAD, TO - 1, TO - 1, 1'b0);
  endtask

  task automatic test_illegal();
    run_instr("illegal0", 4'd0, 0, 0, 1'b0);
    do_reset("illegal_rst");
    run_instr("post_rst", OP, 1, 0, 1'b0);
    run_instr("illegal13", 4'd13, 0, 0, 1'b0);
    do_reset("illegal_rst2");
  endtask

  task automatic test_timeouts();
    run_instr("imem_to", OP, TO, 0, 1'b0);
    do_reset("imem_to_rst");
    run_instr("dmem_to", LOAD, 0, TO, 1'b0);
    do_reset("dmem_to_rst");
  endtask

  task automatic test_reset_mid_mem();
    run_instr("pre_mid", JAL, 0, 0, 1'b0);
    @(negedge clk);
    bus.imem_ack = 1'b1;
    @(negedge clk);
    bus.imem_ack   = 1'b0;
    bus.instr_kind = LOAD;
    @(negedge clk);
    @(negedge clk);
    bus.dmem_ack = 1'b0;
    #1;
    checks++;
    if (bus.dmem_req !== 1'b1 || bus.instret !== 32'd1) $display("FAIL mid_mem before: dmem_req %b instret %0d, required 1 1", bus.dmem_req, bus.instret);
    else passed++;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.dmem_req !== 1'b0 || bus.instret !== 32'd0 || bus.state_o !== 3'd0) $display("FAIL mid_mem reset: dmem_req %b instret %0d state %0d, required 0 0 0", bus.dmem_req, bus.instret, bus.state_o);
    else passed++;
    @(negedge clk);
    rst_n   = 1'b1;
    exp_ret = '0;
    run_instr("restart", LOAD, 0, 1, 1'b0);
    @(negedge clk);
    #1;
    checks++;
    if (bus.instret !== exp_ret) $display("FAIL final instret: got %0d, required %0d", bus.instret, exp_ret);
    else passed++;
  endtask

  initial begin
    bus.imem_ack     = 1'b0;
    bus.dmem_ack     = 1'b0;
    bus.branch_taken = 1'b0;
    bus.instr_kind   = 4'd0;
    test_reset();
    test_lui();
    test_store();
    test_branch();
    test_random();
    test_illegal();
    test_timeouts();
    test_reset_mid_mem();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d done", passed, checks);
    $fatal(1);
  end
endmodule
